alu_pipe: RTL and testbench

- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Accepts one operation per cycle over a valid/ready handshake and returns a registered result with a C/Z/N/V flag set.
- A persistent carry register allows multi-word add/subtract chaining.
- Sits between the lab datapath register file and the result bus; the downstream side may stall it.

---
 rtl/alu_pipe.sv | 175 +++++++++++++++++
 tb/tb_alu_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Registered ALU with valid/ready handshake on both sides, one
//            result register (no skid buffer), C/Z/N/V flags, a persistent
//            carry register for multi-word add/subtract chaining, and an
//            accepted-operation counter.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            in_valid/in_ready - request handshake (in_ready combinational)
//            op, a, b          - opcode and operands (b[log2(WIDTH)-1:0] = SHL amount)
//            clr_carry         - clears the carry register
//            sat               - saturating ADD/ADDC/SUB/SUBB (ALU_SAT_EN builds)
//            out_valid/out_ready - result handshake
//            result, flag_c/z/n/v - registered result and flags
//            carry_q           - carry register
//            op_count          - accepted-operation counter (wraps)
// Macro    : ALU_SAT_EN enables saturation; otherwise sat is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_carry,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             carry_q,
    output logic [CNT_W-1:0] op_count
);

    localparam int         c_SH_W   = $clog2(WIDTH);
    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_OR   = 3'b011;
    localparam logic [2:0] c_OP_XOR  = 3'b100;
    localparam logic [2:0] c_OP_ADDC = 3'b101;
    localparam logic [2:0] c_OP_SUBB = 3'b110;
    localparam logic [2:0] c_OP_SHL  = 3'b111;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_flag_c;
    logic             r_flag_z;
    logic             r_flag_n;
    logic             r_flag_v;
    logic             r_carry;
    logic [CNT_W-1:0] r_op_count;

    logic             w_accept;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shx;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_upd_carry;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Subtraction is a + ~b + cin, so the adder carry-out is the no-borrow bit.
    always_comb begin
        w_b_eff = b;
        w_cin   = 1'b0;
        case (op)
            c_OP_SUB:  begin w_b_eff = ~b; w_cin = 1'b1;    end
            c_OP_ADDC: begin w_b_eff = b;  w_cin = r_carry; end
            c_OP_SUBB: begin w_b_eff = ~b; w_cin = r_carry; end
            default:   begin w_b_eff = b;  w_cin = 1'b0;    end
        endcase
    end

    assign w_sum = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
    // Extra top bit catches the last bit shifted out; it is 0 for a zero shift.
    assign w_shx = {1'b0, a} << b[c_SH_W-1:0];

    always_comb begin
        w_raw       = '0;
        w_c         = 1'b0;
        w_v         = 1'b0;
        w_upd_carry = 1'b0;
        case (op)
            c_OP_ADD, c_OP_SUB, c_OP_ADDC, c_OP_SUBB: begin
                w_raw       = w_sum[WIDTH-1:0];
                w_c         = w_sum[WIDTH];
                w_v         = (a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != a[WIDTH-1]);
                w_upd_carry = 1'b1;
            end
            c_OP_AND: w_raw = a & b;
            c_OP_OR:  w_raw = a | b;
            c_OP_XOR: w_raw = a ^ b;
            c_OP_SHL: begin
                w_raw       = w_shx[WIDTH-1:0];
                w_c         = w_shx[WIDTH];
                w_upd_carry = 1'b1;
            end
            default: w_raw = '0;
        endcase
    end

`ifdef ALU_SAT_EN
    // Saturation only alters the result; C, V and the carry register stay raw.
    always_comb begin
        w_res = w_raw;
        if (sat) begin
            if (((op == c_OP_ADD) || (op == c_OP_ADDC)) && w_c)
                w_res = '1;
            else if (((op == c_OP_SUB) || (op == c_OP_SUBB)) && !w_c)
                w_res = '0;
        end
    end
`else
    logic w_unused_sat;
    assign w_unused_sat = sat;
    assign w_res        = w_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flag_c    <= 1'b0;
            r_flag_z    <= 1'b0;
            r_flag_n    <= 1'b0;
            r_flag_v    <= 1'b0;
            r_carry     <= 1'b0;
            r_op_count  <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_flag_c    <= w_c;
                r_flag_z    <= (w_res == '0);
                r_flag_n    <= w_res[WIDTH-1];
                r_flag_v    <= w_v;
                r_op_count  <= r_op_count + CNT_W'(1);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            // clr_carry wins over the update from an operation in the same cycle.
            if (clr_carry)
                r_carry <= 1'b0;
            else if (w_accept && w_upd_carry)
                r_carry <= w_c;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_c    = r_flag_c;
    assign flag_z    = r_flag_z;
    assign flag_n    = r_flag_n;
    assign flag_v    = r_flag_v;
    assign carry_q   = r_carry;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Self-checking bench for alu_pipe. Drives a WIDTH=4 and a WIDTH=8
//            instance from shared stimulus; an arithmetic reference model is
//            compared against both every cycle, plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr_carry;
    logic       sat;
    logic       out_ready;

    logic       rdy4, vld4, c4, z4, n4, v4, cq4;
    logic [3:0] res4;
    logic [7:0] cnt4;
    logic       rdy8, vld8, c8, z8, n8, v8, cq8;
    logic [7:0] res8;
    logic [7:0] cnt8;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // reference state, index 0 = WIDTH 4, index 1 = WIDTH 8
    int m_valid[2];
    int m_res[2];
    int m_c[2];
    int m_z[2];
    int m_n[2];
    int m_v[2];
    int m_carry[2];
    int m_cnt[2];

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .op(op),
        .a(a[3:0]), .b(b[3:0]), .clr_carry(clr_carry), .sat(sat),
        .out_valid(vld4), .out_ready(out_ready), .result(res4),
        .flag_c(c4), .flag_z(z4), .flag_n(n4), .flag_v(v4),
        .carry_q(cq4), .op_count(cnt4)
    );

    alu_pipe #(.WIDTH(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .op(op),
        .a(a), .b(b), .clr_carry(clr_carry), .sat(sat),
        .out_valid(vld8), .out_ready(out_ready), .result(res8),
        .flag_c(c8), .flag_z(z8), .flag_n(n8), .flag_v(v8),
        .carry_q(cq8), .op_count(cnt8)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit ovf(input int s, input int w);
        return (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
    endfunction

    // Plain integer arithmetic on the operation definitions.
    function automatic void model_op(input int w, input int o, input int ai, input int bi,
                                     input int cq, input int s,
                                     output int r, output int c, output int v);
        int mask, av, bv, sa, sb, t, sh, bor;
        mask = (1 << w) - 1;
        av   = ai & mask;
        bv   = bi & mask;
        sa   = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
        sb   = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
        bor  = 1 - cq;
        r = 0; c = 0; v = 0;
        case (o)
            0: begin t = av + bv;      r = t & mask; c = t >> w; v = ovf(sa + sb, w); end
            1: begin t = av - bv;      r = t & mask; c = (av >= bv) ? 1 : 0; v = ovf(sa - sb, w); end
            5: begin t = av + bv + cq; r = t & mask; c = t >> w; v = ovf(sa + sb + cq, w); end
            6: begin t = av - bv - bor; r = t & mask; c = (av >= bv + bor) ? 1 : 0; v = ovf(sa - sb - bor, w); end
            2: r = av & bv;
            3: r = av | bv;
            4: r = av ^ bv;
            default: begin
                sh = bv % w;
                r  = (av << sh) & mask;
                c  = (sh == 0) ? 0 : ((av >> (w - sh)) & 1);
            end
        endcase
`ifdef ALU_SAT_EN
        if (s != 0) begin
            if ((o == 0 || o == 5) && c == 1) r = mask;
            else if ((o == 1 || o == 6) && c == 0) r = 0;
        end
`endif
    endfunction

    // Reference model advances on each rising edge from the inputs held there.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int w, r, c, v, rdy;
            w = (k == 0) ? 4 : 8;
            if (rst) begin
                m_valid[k] = 0; m_res[k] = 0; m_c[k] = 0; m_z[k] = 0;
                m_n[k] = 0; m_v[k] = 0; m_carry[k] = 0; m_cnt[k] = 0;
            end else begin
                rdy = (m_valid[k] == 0 || out_ready) ? 1 : 0;
                if (in_valid && rdy == 1) begin
                    model_op(w, int'(op), int'(a), int'(b), m_carry[k], int'(sat), r, c, v);
                    m_valid[k] = 1;
                    m_res[k]   = r;
                    m_c[k]     = c;
                    m_v[k]     = v;
                    m_z[k]     = (r == 0) ? 1 : 0;
                    m_n[k]     = (r >> (w - 1)) & 1;
                    m_cnt[k]   = (m_cnt[k] + 1) % 256;
                    if (!(op == 3'd2 || op == 3'd3 || op == 3'd4)) m_carry[k] = c;
                end else if (out_ready) begin
                    m_valid[k] = 0;
                end
                if (clr_carry) m_carry[k] = 0;
            end
        end
    end

    // Single compare process, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready4",  rdy4, (m_valid[0] == 0 || out_ready) ? 1 : 0);
            check("in_ready8",  rdy8, (m_valid[1] == 0 || out_ready) ? 1 : 0);
            check("out_valid4", vld4, m_valid[0]);
            check("out_valid8", vld8, m_valid[1]);
            check("carry_q4",   cq4,  m_carry[0]);
            check("carry_q8",   cq8,  m_carry[1]);
            check("op_count4",  cnt4, m_cnt[0]);
            check("op_count8",  cnt8, m_cnt[1]);
            if (m_valid[0] == 1) begin
                check("result4", res4, m_res[0]);
                check("flag_c4", c4, m_c[0]);
                check("flag_z4", z4, m_z[0]);
                check("flag_n4", n4, m_n[0]);
                check("flag_v4", v4, m_v[0]);
            end
            if (m_valid[1] == 1) begin
                check("result8", res8, m_res[1]);
                check("flag_c8", c8, m_c[1]);
                check("flag_z8", z8, m_z[1]);
                check("flag_n8", n8, m_n[1]);
                check("flag_v8", v8, m_v[1]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [7:0] ai, input logic [7:0] bi,
                         input logic clr, input logic s);
        in_valid  = 1'b1;
        op        = o;
        a         = ai;
        b         = bi;
        clr_carry = clr;
        sat       = s;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        clr_carry = 1'b0;
        sat       = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [7:0] ai, input logic [7:0] bi,
                         input logic clr, input logic s);
        drive(o, ai, bi, clr, s);
        tick();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 3'd0; a = 8'd0; b = 8'd0;
        clr_carry = 1'b0; sat = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        rst = 1'b0;
        check("reset_out_valid", vld8, 0);
        check("reset_result",    res8, 0);
        check("reset_count",     cnt8, 0);

        // ADD 9+8 at WIDTH 4
        do_op(3'd0, 8'd9, 8'd8, 1'b0, 1'b0);
        check("add_res4", res4, 1);
        check("add_c4",   c4, 1);
        check("add_v4",   v4, 1);
        check("add_cq4",  cq4, 1);
        check("add_cnt4", cnt4, 1);
        check("model_add_res4", m_res[0], 1);
        check("model_add_v4",   m_v[0], 1);
        check("add_res8", res8, 17);

        // SUB 3-5 then 5-5 at WIDTH 4
        do_op(3'd1, 8'd3, 8'd5, 1'b0, 1'b0);
        check("sub_res4", res4, 14);
        check("sub_c4",   c4, 0);
        check("sub_n4",   n4, 1);
        check("sub_z4",   z4, 0);
        check("model_sub_res4", m_res[0], 14);
        do_op(3'd1, 8'd5, 8'd5, 1'b0, 1'b0);
        check("subz_res4", res4, 0);
        check("subz_z4",   z4, 1);
        check("subz_c4",   c4, 1);

        // 16-bit chain 0x01FF + 0x0001 on the WIDTH 8 instance
        clr_carry = 1'b1;
        tick();
        clr_carry = 1'b0;
        check("clr_idle_cq8", cq8, 0);
        drive(3'd0, 8'hFF, 8'h01, 1'b0, 1'b0);
        tick();
        check("chain_lo_res8", res8, 8'h00);
        check("chain_lo_c8",   c8, 1);
        drive(3'd5, 8'h01, 8'h00, 1'b0, 1'b0);
        tick();
        idle();
        check("chain_hi_res8", res8, 8'h02);
        check("chain_hi_c8",   c8, 0);
        check("model_chain_hi8", m_res[1], 2);

        // clr_carry alongside an accepted op: old carry used, flag raw, register cleared
        do_op(3'd0, 8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(3'd5, 8'h00, 8'h00, 1'b1, 1'b0);
        check("clr_addc_res8", res8, 1);
        check("clr_addc_cq8",  cq8, 0);
        do_op(3'd0, 8'hF0, 8'h20, 1'b1, 1'b0);
        check("clr_add_res8", res8, 8'h10);
        check("clr_add_c8",   c8, 1);
        check("clr_add_cq8",  cq8, 0);

        // backpressure
        tick();
        out_ready = 1'b0;
        drive(3'd4, 8'h5A, 8'h0F, 1'b0, 1'b0);
        tick();
        drive(3'd3, 8'h33, 8'h44, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_ready8", rdy8, 0);
            check("stall_res8",   res8, 8'h55);
            tick();
        end
        check("stall_cnt_hold", cnt8, m_cnt[1]);
        out_ready = 1'b1;
        #1;
        check("release_ready8", rdy8, 1);
        tick();
        idle();
        check("release_res8", res8, 8'h77);

        // SHL
        do_op(3'd7, 8'h81, 8'h01, 1'b0, 1'b0);
        check("shl1_res8", res8, 8'h02);
        check("shl1_c8",   c8, 1);
        do_op(3'd2, 8'hFF, 8'h0F, 1'b0, 1'b0);
        check("and_cq8",   cq8, 1);
        check("and_res8",  res8, 8'h0F);
        do_op(3'd7, 8'h81, 8'h00, 1'b0, 1'b0);
        check("shl0_res8", res8, 8'h81);
        check("shl0_c8",   c8, 0);

        // reset while stalled
        tick();
        out_ready = 1'b0;
        do_op(3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        check("pre_rst_valid8", vld8, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid8", vld8, 0);
        check("rst_cq8",    cq8, 0);
        check("rst_cnt8",   cnt8, 0);
        out_ready = 1'b1;

        // saturation request
        do_op(3'd0, 8'd12, 8'd7, 1'b0, 1'b1);
`ifdef ALU_SAT_EN
        check("sat_add_res4", res4, 15);
`else
        check("sat_add_res4", res4, 3);
`endif
        check("sat_add_c4", c4, 1);
        do_op(3'd1, 8'd3, 8'd5, 1'b0, 1'b1);
`ifdef ALU_SAT_EN
        check("sat_sub_res4", res4, 0);
`else
        check("sat_sub_res4", res4, 14);
`endif

        // randomised traffic against the model, long enough to wrap op_count
        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = 3'($urandom_range(0, 7));
            a         = 8'($urandom);
            b         = 8'($urandom);
            clr_carry = ($urandom_range(0, 7) == 0);
            sat       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle();
        out_ready = 1'b1;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
